// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: branch opcodes,
// default reset PC, BHT counter states and small helper functions.
// Used by if_fetch_unit and branch_history_table.
package if_fetch_unit_pkg;

  // Opcodes (instr[31:26]) of the conditional branches that get predicted
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  // Fetch address loaded when reset is asserted
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Two-bit saturating counter states of one BHT entry
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  // True when the instruction word is beq or bne
  function automatic logic isCondBranch(input logic [31:0] instr);
    return (instr[31:26] == OP_BEQ) || (instr[31:26] == OP_BNE);
  endfunction

  // Saturating counter step: move toward ST when taken, toward SNT when not
  function automatic bht_state_e nextCounter(input bht_state_e cur,
                                             input logic       taken);
    bht_state_e nxt;
    nxt = cur;
    if (taken) begin
      case (cur)
        SNT:     nxt = WNT;
        WNT:     nxt = WT;
        WT:      nxt = ST;
        default: nxt = ST;
      endcase
    end else begin
      case (cur)
        ST:      nxt = WT;
        WT:      nxt = WNT;
        WNT:     nxt = SNT;
        default: nxt = SNT;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/if_fetch_unit_branch_history_table.sv
// Branch history table: an untagged array of 2-bit saturating counters with
// one combinational read port (prediction) and one synchronous update port
// (training from EX). A same-cycle read of the entry being updated returns
// the old counter; the new value is visible from the next cycle.
module branch_history_table
  import if_fetch_unit_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_rdIdx,
  output bht_state_e       o_rdState,
  input  logic             i_updValid,
  input  logic [IDX_W-1:0] i_updIdx,
  input  logic             i_updTaken
);

  localparam int ENTRIES = 2 ** IDX_W;

  bht_state_e r_table [ENTRIES];

  // Counter array: all entries weakly not-taken on reset, trained by EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= WNT;
      end
    end else if (i_updValid) begin
      r_table[i_updIdx] <= nextCounter(r_table[i_updIdx], i_updTaken);
    end
  end

  // Prediction read port sees the counter as stored before this edge
  always_comb begin
    o_rdState = r_table[i_rdIdx];
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instruction-memory address
// and presents instruction, PC and prediction bit to the IF/ID register.
// Next-PC priority: redirect, stall (hold), predicted-taken target, PC+4.
// Optional feature macro: BRANCH_PREDICT_EN builds the branch history table
// and predicted-target path; without it fetch is static not-taken.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BHT_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_if,
  output logic [31:0] instr_if,
  output logic        bp_taken_if
);

  logic [31:0] r_pc;
  logic [31:0] w_seqPc;
  logic [31:0] w_nextPc;
  logic        w_bpTaken;
  logic [31:0] w_target;

  assign w_seqPc = r_pc + 32'd4;

`ifdef BRANCH_PREDICT_EN
  logic        w_isCondBranch;
  logic [31:0] w_immOffset;
  bht_state_e  w_rdState;
  logic        w_unused;

  assign w_isCondBranch = isCondBranch(imem_rdata);
  assign w_immOffset    = {{14{imem_rdata[15]}}, imem_rdata[15:0], 2'b00};
  assign w_target       = w_seqPc + w_immOffset;

  // Only the index bits of the resolved branch PC select a counter
  assign w_unused = ^{upd_pc[31:BHT_IDX_W+2], upd_pc[1:0]};

  branch_history_table #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rdIdx    (r_pc[BHT_IDX_W+1:2]),
    .o_rdState  (w_rdState),
    .i_updValid (upd_valid),
    .i_updIdx   (upd_pc[BHT_IDX_W+1:2]),
    .i_updTaken (upd_taken)
  );

  assign w_bpTaken = w_isCondBranch & w_rdState[1];
`else
  logic w_unused;

  // Training inputs have no effect in the static not-taken build
  assign w_unused  = ^{upd_valid, upd_pc, upd_taken};
  assign w_target  = w_seqPc;
  assign w_bpTaken = 1'b0;
`endif

  // Next-PC selection; redirect wins even over a stall
  always_comb begin
    w_nextPc = w_seqPc;
    if (redirect_valid) begin
      w_nextPc = redirect_pc;
    end else if (stall) begin
      w_nextPc = r_pc;
    end else if (w_bpTaken) begin
      w_nextPc = w_target;
    end
  end

  // Program counter register, returned to RESET_PC asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_nextPc;
    end
  end

  assign imem_addr   = r_pc;
  assign pc_if       = r_pc;
  assign instr_if    = imem_rdata;
  assign bp_taken_if = w_bpTaken;

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the five-stage pipeline: holds the program counter, drives the instruction-memory address, and produces the IF-side instruction word, PC and branch-prediction bit consumed by the IF/ID pipeline register. It selects the next PC from EX-stage redirects, hazard stalls, a 2-bit-counter branch history table (BHT) and sequential PC+4. BHT training comes from the EX stage when a conditional branch resolves.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- BHT_IDX_W, 6, BHT index width; 2**BHT_IDX_W entries, indexed by pc[BHT_IDX_W+1:2]

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard-unit stall; hold PC
- redirect_valid  in  1  EX-stage mispredict or jump correction
- redirect_pc  in  32  corrected fetch address
- upd_valid  in  1  EX resolved a conditional branch this cycle
- upd_pc  in  32  PC of the resolved branch
- upd_taken  in  1  actual branch outcome
- imem_addr  out  32  instruction-memory address (= pc_if)
- imem_rdata  in  32  combinational instruction-memory read data
- pc_if  out  32  current fetch PC
- instr_if  out  32  fetched instruction (= imem_rdata)
- bp_taken_if  out  1  prediction made for instr_if

## Operation
- PC register is the only architectural state besides the BHT. imem_addr, pc_if, instr_if and bp_taken_if are combinational from PC, imem_rdata and the BHT.
- Conditional branch: opcode instr_if[31:26] is 6'b000100 (beq) or 6'b000101 (bne). No other opcode is predicted.
- bp_taken_if = is_cond_branch AND bht[pc_if index][1].
- Predicted target: pc_if + 4 + (sign_extend(instr_if[15:0]) << 2). 32-bit modular arithmetic; wrap-around is silent.
- Next-PC priority, highest first:
  - redirect_valid: load redirect_pc.
  - stall: hold PC.
  - bp_taken_if: load predicted target.
  - Otherwise: load pc_if + 4.
- redirect_valid overrides stall. The hazard unit never asserts both for a legitimate case, but the priority is fixed.
- BHT update on upd_valid, at index upd_pc[BHT_IDX_W+1:2]:
  - Saturating 2-bit counter: increment if upd_taken, decrement otherwise.
  - Saturates at 2'b11 and 2'b00.
  - No tags; aliasing is accepted.
- Updates apply regardless of stall and redirect_valid.
- Same-cycle read and update of one index: the prediction uses the old counter value; the new value is visible from the next cycle.

## Timing
- Reset (rst_n low, asynchronous):
  - PC = RESET_PC.
  - All BHT entries = 2'b01 (weakly not-taken).
  - Consequently pc_if = imem_addr = RESET_PC and bp_taken_if = 0.
- First edge after rst_n deasserts: normal next-PC selection.
- Reset asserted mid-operation: PC and BHT return to reset values immediately, independent of clk. Pending redirect or update is discarded.
- Redirect latency: redirect_pc appears on pc_if one cycle after the edge that samples redirect_valid.
- Prediction latency: 0 cycles. The taken target is on pc_if the cycle after the branch is on instr_if.
- Stall: pc_if, instr_if and bp_taken_if stay unchanged for every stalled cycle, provided memory and the BHT index are stable.

## Configuration
- BRANCH_PREDICT_EN defined: BHT and predicted-target path are built as described above.
- BRANCH_PREDICT_EN undefined:
  - No BHT storage.
  - bp_taken_if is tied to 0 (static not-taken).
  - upd_* inputs are ignored.
  - Next PC is redirect_pc, held PC, or pc_if + 4.

## Structure
Shared package holds:
- Opcode constants OP_BEQ and OP_BNE.
- RESET_PC default.
- BHT counter state constants: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.

Sub-module branch_history_table holds the counter array:
- One combinational read port and one synchronous update port.
- Asynchronous reset.
- Instantiated only under BRANCH_PREDICT_EN.

## Test plan
- Reset: release rst_n with imem returning NOP -> pc_if = 32'h0000_3000, then 32'h0000_3004 and 32'h0000_3008 on successive edges; bp_taken_if = 0.
- Redirect over stall: assert stall and redirect_valid together, redirect_pc = 32'h0000_3100 -> pc_if = 32'h0000_3100 next cycle.
- BHT training: three upd_valid/upd_taken=1 updates for upd_pc = 32'h0000_3010; then fetch beq at 32'h0000_3010 with imm = 16'h0004 -> bp_taken_if = 1; next pc_if = 32'h0000_3024.
- Saturation and back-off: from ST, two not-taken updates give WNT -> beq at that PC predicts not-taken; pc_if advances by 4.
- Negative offset: beq at 32'h0000_3040 predicted taken with imm = 16'hFFFC -> next pc_if = 32'h0000_3034.
- Async reset mid-stall: drop rst_n between edges while stall = 1 and PC = 32'h0000_3200 -> pc_if = 32'h0000_3000 immediately; trained entries read 2'b01.
